retire_rat: RTL

//  Retirement register alias table (RRAT) sitting directly downstream of the ROB commit port.

---
 rtl/retire_rat.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/retire_rat.sv
// Retirement register alias table: commits (rd_arch, rd_phy) into the committed map and
// queues each superseded physical register for return to the free list.
module retire_rat #(
   parameter int ARF_DEPTH = 32,
   parameter int ARF_IDX   = 5,
   parameter int PRF_DEPTH = 64,
   parameter int PRF_IDX   = 6,
   parameter int FQ_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         commit_valid,
   output logic                         commit_ready,
   input  logic [ARF_IDX-1:0]           commit_rd_arch,
   input  logic [PRF_IDX-1:0]           commit_rd_phy,
   output logic                         free_valid,
   input  logic                         free_ready,
   output logic [PRF_IDX-1:0]           free_phy,
   output logic [ARF_DEPTH*PRF_IDX-1:0] rrat_flat,
   output logic [31:0]                  retire_count
);
   localparam int FQ_IDX = $clog2(FQ_DEPTH);
   localparam int CNT_W  = FQ_IDX + 1;

   logic [PRF_IDX-1:0]          rrat_r [ARF_DEPTH];
   logic [PRF_IDX-1:0]          queue_r [FQ_DEPTH];
   logic [FQ_IDX-1:0]           head_r, tail_r;
   logic [CNT_W-1:0]            count_r;
   logic                        free_valid_r, commit_ready_r;
   logic [PRF_IDX-1:0]          free_phy_r;
   logic [31:0]                 retire_count_r;

   logic                        acc_s, enq_s, deq_s;
   logic [PRF_IDX-1:0]          old_s, free_phy_nxt_s;
   logic [FQ_IDX-1:0]           head_nxt_s;
   logic [CNT_W-1:0]            remain_s, count_nxt_s;
   logic [FQ_DEPTH*PRF_IDX-1:0] queue_flat_s;

   // Next-state decode; free port outputs are precomputed so they can be registered.
   always_comb begin
      acc_s = commit_valid && commit_ready_r;
      enq_s = acc_s && (commit_rd_arch != '0);
      deq_s = free_valid_r && free_ready;
      old_s = rrat_r[commit_rd_arch];
      if (deq_s) begin
         head_nxt_s = head_r + FQ_IDX'(1);
         remain_s   = count_r - CNT_W'(1);
      end else begin
         head_nxt_s = head_r;
         remain_s   = count_r;
      end
      if (enq_s) begin
         count_nxt_s = remain_s + CNT_W'(1);
      end else begin
         count_nxt_s = remain_s;
      end
      // When the queue is otherwise empty the new head is the entry being enqueued now.
      if (count_nxt_s == '0) begin
         free_phy_nxt_s = '0;
      end else if (enq_s && (remain_s == '0)) begin
         free_phy_nxt_s = old_s;
      end else begin
         free_phy_nxt_s = queue_r[head_nxt_s];
      end
   end

   // Map, return queue, and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARF_DEPTH; i++) rrat_r[i] <= PRF_IDX'(i);
         for (int j = 0; j < FQ_DEPTH; j++) queue_r[j] <= '0;
         head_r         <= '0;
         tail_r         <= '0;
         count_r        <= '0;
         free_valid_r   <= 1'b0;
         free_phy_r     <= '0;
         commit_ready_r <= 1'b1;
         retire_count_r <= 32'd0;
      end else begin
         if (enq_s) begin
            rrat_r[commit_rd_arch] <= commit_rd_phy;
            queue_r[tail_r]        <= old_s;
            tail_r                 <= tail_r + FQ_IDX'(1);
         end
         if (acc_s) begin
            retire_count_r <= retire_count_r + 32'd1;
         end
         head_r         <= head_nxt_s;
         count_r        <= count_nxt_s;
         free_valid_r   <= (count_nxt_s != '0);
         free_phy_r     <= free_phy_nxt_s;
         commit_ready_r <= (count_nxt_s != CNT_W'(FQ_DEPTH));
      end
   end

   for (genvar g = 0; g < ARF_DEPTH; g++) begin : g_map
      assign rrat_flat[g*PRF_IDX +: PRF_IDX] = rrat_r[g];
   end
   for (genvar q = 0; q < FQ_DEPTH; q++) begin : g_queue
      assign queue_flat_s[q*PRF_IDX +: PRF_IDX] = queue_r[q];
   end

   assign commit_ready = commit_ready_r;
   assign free_valid   = free_valid_r;
   assign free_phy     = free_phy_r;
   assign retire_count = retire_count_r;

   retire_rat_chk #(
      .ARF_DEPTH(ARF_DEPTH), .PRF_DEPTH(PRF_DEPTH), .PRF_IDX(PRF_IDX),
      .FQ_DEPTH(FQ_DEPTH), .FQ_IDX(FQ_IDX)
   ) u_chk (
      .clk(clk), .rst(rst), .map_flat(rrat_flat), .queue_flat(queue_flat_s),
      .head(head_r), .count(count_r)
   );
endmodule

// Invariant checker: every preg held by the map or the return queue is unique.
module retire_rat_chk #(
   parameter int ARF_DEPTH = 32,
   parameter int PRF_DEPTH = 64,
   parameter int PRF_IDX   = 6,
   parameter int FQ_DEPTH  = 4,
   parameter int FQ_IDX    = 2
) (
   input logic                         clk,
   input logic                         rst,
   input logic [ARF_DEPTH*PRF_IDX-1:0] map_flat,
   input logic [FQ_DEPTH*PRF_IDX-1:0]  queue_flat,
   input logic [FQ_IDX-1:0]            head,
   input logic [FQ_IDX:0]              count
);
   logic distinct_s;

   function automatic logic pregs_distinct(
      input logic [ARF_DEPTH*PRF_IDX-1:0] m,
      input logic [FQ_DEPTH*PRF_IDX-1:0]  qf,
      input logic [FQ_IDX-1:0]            hd,
      input logic [FQ_IDX:0]              cnt
   );
      logic [PRF_DEPTH-1:0] seen;
      logic [PRF_IDX-1:0]   p;
      logic [FQ_IDX-1:0]    idx;
      logic                 ok;
      seen = '0;
      ok   = 1'b1;
      for (int i = 0; i < ARF_DEPTH; i++) begin
         p = m[i*PRF_IDX +: PRF_IDX];
         if (seen[p]) ok = 1'b0;
         seen[p] = 1'b1;
      end
      for (int k = 0; k < FQ_DEPTH; k++) begin
         idx = hd + FQ_IDX'(k);
         if ((FQ_IDX+1)'(k) < cnt) begin
            p = qf[int'(idx)*PRF_IDX +: PRF_IDX];
            if (seen[p]) ok = 1'b0;
            seen[p] = 1'b1;
         end
      end
      return ok;
   endfunction

   // Recompute uniqueness over the current registered state.
   always_comb begin
      distinct_s = pregs_distinct(map_flat, queue_flat, head, count);
   end

   a_distinct: assert property (@(posedge clk) disable iff (rst) distinct_s);
endmodule
